riscv_mc_controller: RTL and testbench

- Multicycle control sequencer for the RV32I core datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select, write enable and ALU operation.
- Owns the memory request handshake, including a bus timeout, and flags illegal instructions.

---
 rtl/riscv_mc_controller.sv | 175 +++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle RV32I control sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives all datapath
// selects, write enables and the ALU operation. It owns the memory handshake with a bus
// timeout and flags illegal instructions.
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   instr_i, zero_i       instruction register contents, ALU zero flag
//   mem_ready_i           memory completes the current request this cycle
//   mem_req_o, mem_we_o   memory request (held until ready), store qualifier
//   adrsrc_o ... alucontrol_o   datapath mux selects, write enables and ALU operation
//   illegal_o, bus_err_o  sticky illegal-instruction and memory-timeout flags
//   state_dbg_o           current state encoding
module riscv_mc_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        adrsrc_o,
  output logic        irwrite_o,
  output logic        pcwrite_o,
  output logic        regwrite_o,
  output logic [1:0]  alusrca_o,
  output logic [1:0]  alusrcb_o,
  output logic [1:0]  resultsrc_o,
  output logic [2:0]  alucontrol_o,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic [3:0]  state_dbg_o
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9,
    JAL = 4'd10, TRAP = 4'd15
  } state_t;
  // The counter only has to hold up to MEM_TIMEOUT-1 waiting cycles.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic mem_req, mem_we, adrsrc, irwrite, pcwrite, regwrite, timeout;
  logic [1:0] alusrca, alusrcb, resultsrc;
  logic [2:0] alucontrol;
  logic [6:0] op;
  logic [2:0] f3;
  logic alu_ok, unused_instr;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign alu_ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};
  function automatic logic [2:0] alu_op(input logic [2:0] fn3, input logic sub);
    return (fn3 == 3'b000) ? (sub ? 3'b001 : 3'b000) :
           (fn3 == 3'b010) ? 3'b101 :
           (fn3 == 3'b110) ? 3'b011 :
           (fn3 == 3'b111) ? 3'b010 : 3'b000;
  endfunction
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adrsrc     = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    resultsrc  = 2'b00;
    alucontrol = 3'b000;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready_i;
        pcwrite   = mem_ready_i;
        state_d   = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        // Width and ALU funct3 legality is resolved here so EXEC/MEM states never see a bad op.
        case (op)
          7'b0000011, 7'b0100011: state_d = (f3 == 3'b010) ? MEMADR : TRAP;
          7'b0110011:             state_d = alu_ok ? EXECR : TRAP;
          7'b0010011:             state_d = alu_ok ? EXECI : TRAP;
          7'b1100011:             state_d = BEQ;
          7'b1101111:             state_d = JAL;
          default:                state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = instr_i[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
        state_d = mem_ready_i ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adrsrc  = 1'b1;
        state_d = mem_ready_i ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alusrca    = 2'b10;
        alucontrol = alu_op(f3, instr_i[30]);
        state_d    = ALUWB;
      end
      EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = alu_op(f3, 1'b0);
        state_d    = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        alusrca    = 2'b10;
        alucontrol = 3'b001;
        pcwrite    = zero_i && (f3 == 3'b000);
        state_d    = (f3 == 3'b000) ? FETCH : TRAP;
      end
      JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
        state_d = ALUWB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
    // A completion in the final allowed cycle wins over the timeout.
    timeout = (MEM_TIMEOUT != 0) && mem_req && !mem_ready_i && (cnt_q == LAST);
    if (timeout) state_d = TRAP;
    cnt_d     = (mem_req && !mem_ready_i && state_d == state_q) ? cnt_q + 1'b1 : '0;
    illegal_d = illegal_q | (state_d == TRAP && state_q != TRAP && !timeout);
    bus_err_d = bus_err_q | timeout;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end
  // Gating with rst_ni drops the request and every enable the instant reset asserts.
  assign {mem_req_o, mem_we_o, adrsrc_o, irwrite_o, pcwrite_o, regwrite_o,
          alusrca_o, alusrcb_o, resultsrc_o, alucontrol_o} = rst_ni ?
         {mem_req, mem_we, adrsrc, irwrite, pcwrite, regwrite,
          alusrca, alusrcb, resultsrc, alucontrol} : 15'd0;
  assign illegal_o   = illegal_q;
  assign bus_err_o   = bus_err_q;
  assign state_dbg_o = state_q;
endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb_riscv_mc_controller: scoreboard bench for the multicycle controller.
module tb_riscv_mc_controller;
  logic clk = 1'b0, rst_ni = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic mem_req, mem_we, adrsrc, irwrite, pcwrite, regwrite, illegal, bus_err;
  logic [1:0] alusrca, alusrcb, resultsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_dbg;
  logic [20:0] got;
  typedef struct {logic [20:0] v; string n;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  riscv_mc_controller #(.MEM_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .instr_i(instr), .zero_i(zero), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .adrsrc_o(adrsrc), .irwrite_o(irwrite),
    .pcwrite_o(pcwrite), .regwrite_o(regwrite), .alusrca_o(alusrca), .alusrcb_o(alusrcb),
    .resultsrc_o(resultsrc), .alucontrol_o(alucontrol), .illegal_o(illegal),
    .bus_err_o(bus_err), .state_dbg_o(state_dbg)
  );
  always #5 clk = ~clk;
  assign got = {state_dbg, mem_req, mem_we, adrsrc, irwrite, pcwrite, regwrite,
                alusrca, alusrcb, resultsrc, alucontrol, illegal, bus_err};
  function automatic logic [20:0] mk(input logic [3:0] st, input logic req, we, adr, irw, pcw, rw,
                                     input logic [1:0] a, b, r, input logic [2:0] alu,
                                     input logic ill, be);
    return {st, req, we, adr, irw, pcw, rw, a, b, r, alu, ill, be};
  endfunction
  localparam logic [20:0] RST    = 21'd0;
  localparam logic [20:0] F_WAIT = {4'd0, 6'b100000, 2'd0, 2'd2, 2'd2, 3'd0, 2'b00};
  localparam logic [20:0] F_GO   = {4'd0, 6'b100110, 2'd0, 2'd2, 2'd2, 3'd0, 2'b00};
  localparam logic [20:0] DEC    = {4'd1, 6'b000000, 2'd1, 2'd1, 2'd0, 3'd0, 2'b00};
  localparam logic [20:0] MADR   = {4'd2, 6'b000000, 2'd2, 2'd1, 2'd0, 3'd0, 2'b00};
  localparam logic [20:0] MRD    = {4'd3, 6'b101000, 2'd0, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [20:0] MWB    = {4'd4, 6'b000001, 2'd0, 2'd0, 2'd1, 3'd0, 2'b00};
  localparam logic [20:0] MWR    = {4'd5, 6'b111000, 2'd0, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [20:0] EXR_AD = {4'd6, 6'b000000, 2'd2, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [20:0] EXR_SB = {4'd6, 6'b000000, 2'd2, 2'd0, 2'd0, 3'd1, 2'b00};
  localparam logic [20:0] EXI_AD = {4'd7, 6'b000000, 2'd2, 2'd1, 2'd0, 3'd0, 2'b00};
  localparam logic [20:0] AWB    = {4'd8, 6'b000001, 2'd0, 2'd0, 2'd0, 3'd0, 2'b00};
  localparam logic [20:0] BEQ_T  = {4'd9, 6'b000010, 2'd2, 2'd0, 2'd0, 3'd1, 2'b00};
  localparam logic [20:0] BEQ_N  = {4'd9, 6'b000000, 2'd2, 2'd0, 2'd0, 3'd1, 2'b00};
  localparam logic [20:0] JALS   = {4'd10, 6'b000010, 2'd1, 2'd2, 2'd0, 3'd0, 2'b00};
  localparam logic [20:0] TR_ILL = {4'd15, 6'b000000, 2'd0, 2'd0, 2'd0, 3'd0, 2'b10};
  localparam logic [20:0] TR_BE  = {4'd15, 6'b000000, 2'd0, 2'd0, 2'd0, 3'd0, 2'b01};
  // Drive one cycle's inputs just after a rising edge, queue the expected outputs, advance.
  task automatic step(input logic rst, input logic [31:0] ins, input logic z, rdy,
                      input logic [20:0] v, input string n);
    rst_ni = rst;
    instr = ins;
    zero = z;
    mem_ready = rdy;
    q.push_back('{v: v, n: n});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (got !== e.v) begin
        fails++;
        $display("FAIL %s: got st=%0d ctl=%h flags=%b, expected st=%0d ctl=%h flags=%b",
                 e.n, got[20:17], got[16:2], got[1:0], e.v[20:17], e.v[16:2], e.v[1:0]);
      end
    end
  end
  localparam logic [31:0] ADD = 32'h002081B3, SUB = 32'h402081B3, ADDI = 32'h40208193;
  localparam logic [31:0] LW = 32'h0000A183, SW = 32'h0020A223, BEQI = 32'h00208463;
  localparam logic [31:0] JALI = 32'h008000EF, LWBAD = 32'h0000B183, BNE = 32'h00209463;
  localparam logic [31:0] BAD = 32'hFFFFFFFF;
  initial begin
    @(posedge clk);
    #1;
    step(0, 0, 0, 1, RST, "reset0");
    step(0, 0, 0, 1, RST, "reset1");
    step(1, ADD, 0, 1, F_GO, "add_fetch");
    step(1, ADD, 0, 0, DEC, "add_decode");
    step(1, ADD, 0, 0, EXR_AD, "add_exec");
    step(1, ADD, 0, 0, AWB, "add_wb");
    step(1, SUB, 0, 1, F_GO, "sub_fetch");
    step(1, SUB, 0, 0, DEC, "sub_decode");
    step(1, SUB, 0, 0, EXR_SB, "sub_exec");
    step(1, SUB, 0, 0, AWB, "sub_wb");
    step(1, ADDI, 0, 1, F_GO, "addi_fetch");
    step(1, ADDI, 0, 0, DEC, "addi_decode");
    step(1, ADDI, 0, 0, EXI_AD, "addi_exec");
    step(1, ADDI, 0, 0, AWB, "addi_wb");
    step(1, LW, 0, 1, F_GO, "lw_fetch");
    step(1, LW, 0, 0, DEC, "lw_decode");
    step(1, LW, 0, 0, MADR, "lw_memadr");
    for (int i = 0; i < 3; i++) step(1, LW, 0, 0, MRD, "lw_memread_wait");
    step(1, LW, 0, 1, MRD, "lw_memread_done");
    step(1, LW, 0, 0, MWB, "lw_memwb");
    step(1, SW, 0, 1, F_GO, "sw_fetch");
    step(1, SW, 0, 0, DEC, "sw_decode");
    step(1, SW, 0, 0, MADR, "sw_memadr");
    step(1, SW, 0, 0, MWR, "sw_memwrite_wait");
    step(1, SW, 0, 1, MWR, "sw_memwrite_done");
    step(1, BEQI, 1, 1, F_GO, "beq_t_fetch");
    step(1, BEQI, 1, 0, DEC, "beq_t_decode");
    step(1, BEQI, 1, 0, BEQ_T, "beq_taken");
    step(1, BEQI, 0, 1, F_GO, "beq_n_fetch");
    step(1, BEQI, 0, 0, DEC, "beq_n_decode");
    step(1, BEQI, 0, 0, BEQ_N, "beq_not_taken");
    step(1, JALI, 0, 1, F_GO, "jal_fetch");
    step(1, JALI, 0, 0, DEC, "jal_decode");
    step(1, JALI, 0, 0, JALS, "jal_exec");
    step(1, JALI, 0, 0, AWB, "jal_wb");
    for (int i = 0; i < 15; i++) step(1, ADD, 0, 0, F_WAIT, "late_ready_wait");
    step(1, ADD, 0, 1, F_GO, "late_ready_16th");
    step(1, ADD, 0, 0, DEC, "late_ready_decode");
    step(1, ADD, 0, 0, EXR_AD, "late_ready_exec");
    step(1, ADD, 0, 0, AWB, "late_ready_wb");
    step(1, ADD, 0, 0, F_WAIT, "midreq_wait0");
    step(1, ADD, 0, 0, F_WAIT, "midreq_wait1");
    step(0, ADD, 0, 0, RST, "midreq_reset_drop");
    step(1, LWBAD, 0, 1, F_GO, "lwbad_fetch");
    step(1, LWBAD, 0, 0, DEC, "lwbad_decode");
    for (int i = 0; i < 3; i++) step(1, LWBAD, 0, 1, TR_ILL, "lwbad_trap");
    step(0, LWBAD, 0, 0, RST, "lwbad_reset");
    step(1, BNE, 1, 1, F_GO, "bne_fetch");
    step(1, BNE, 1, 0, DEC, "bne_decode");
    step(1, BNE, 1, 0, BEQ_N, "bne_no_pcwrite");
    step(1, BNE, 1, 0, TR_ILL, "bne_trap");
    step(0, BNE, 0, 0, RST, "bne_reset");
    step(1, BAD, 0, 1, F_GO, "bad_fetch");
    step(1, BAD, 0, 0, DEC, "bad_decode");
    for (int i = 0; i < 22; i++) step(1, BAD, i[0], i[1], TR_ILL, "bad_trap_hold");
    step(0, BAD, 0, 0, RST, "bad_reset");
    step(1, ADD, 0, 0, F_WAIT, "bad_after_reset");
    for (int i = 0; i < 15; i++) step(1, ADD, 0, 0, F_WAIT, "timeout_wait");
    for (int i = 0; i < 3; i++) step(1, ADD, 0, 1, TR_BE, "timeout_trap");
    step(0, ADD, 0, 0, RST, "timeout_reset");
    step(1, ADD, 0, 1, F_GO, "final_fetch");
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
